// File: rtl/popcount_gen_pkg.sv
// Shared constants and types for the exact-popcount vector generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package popcount_gen_pkg;

  // Default vector width and the count width needed to hold 0..N.
  localparam int POP_N  = 27;
  localparam int POP_CW = 5;

  // 16-bit Galois LFSR feedback mask (right-shifting form) and reset seed.
  localparam logic [15:0] LFSR_TAP  = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUILD   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAP) : (s >> 1);
  endfunction

endpackage

// File: rtl/popcount_gen_lfsr.sv
// 16-bit Galois LFSR that steps only when adv is high; reset reloads SEED.
// Latency: new state visible one clock after adv.
// Backpressure: none; the caller gates advancement through adv.
module popcount_gen_lfsr
  import popcount_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] state
);

  // Hold the state unless asked to advance; only reset reloads the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/popcount_vector_gen.sv
// Emits num N-bit vectors per command, each with exactly k ones placed by selection sampling.
// Latency: first out_valid N+1 cycles after the command cycle, then N+1 after each handshake.
// Backpressure: out_vec/out_count/out_last hold while out_valid && !out_ready; commands only taken in IDLE.
module popcount_vector_gen
  import popcount_gen_pkg::*;
#(
  parameter int          N    = POP_N,
  parameter int          CW   = POP_CW,
  parameter int          NUMW = 16,
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CW-1:0]   cmd_count,
  input  logic [NUMW-1:0] cmd_num,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_vec,
  output logic [CW-1:0]   out_count,
  output logic            out_last,
  output logic            err,
  output logic            busy
);

  localparam logic [CW-1:0]   N_CW     = CW'(N);
  localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0]   ONE_CW   = CW'(1);
  localparam logic [NUMW-1:0] ONE_NUM  = NUMW'(1);

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     idx_q;
  logic [CW-1:0]     m_q;
  logic [CW-1:0]     k_q;
  logic [NUMW-1:0]   rem_q;
  logic [N-1:0]      vec_q;
  logic              err_q;
  logic [15:0]       lfsr_q;

  logic              cmd_fire;
  logic              cmd_bad;
  logic              cmd_empty;
  logic              out_fire;
  logic [CW-1:0]     r_rem;
  logic [CW+15:0]    prod;
  logic [CW-1:0]     scaled;
  logic              take_bit;

  assign cmd_fire  = cmd_valid && (state_q == IDLE);
  assign cmd_bad   = cmd_count > N_CW;
  assign cmd_empty = (cmd_num == '0);
  assign out_fire  = (state_q == PRESENT) && out_ready;

  // Selection sampling: take bit i with probability m/r, where r = N - i bits remain.
  // floor(lfsr*r / 2^16) lies in [0, r-1], so m == r always takes and m == 0 never does.
  always_comb begin
    r_rem    = N_CW - idx_q;
    prod     = {{CW{1'b0}}, lfsr_q} * {16'h0000, r_rem};
    scaled   = CW'(prod >> 16);
    take_bit = scaled < m_q;
  end

  popcount_gen_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (state_q == BUILD),
    .state (lfsr_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one BUILD cycle per bit, then present until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire && !cmd_bad && !cmd_empty) begin
          state_d = BUILD;
        end
      end
      BUILD: begin
        if (idx_q == LAST_IDX) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = (rem_q == ONE_NUM) ? IDLE : BUILD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch commands, build the vector bit by bit, count vectors off on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      m_q   <= '0;
      k_q   <= '0;
      rem_q <= '0;
      vec_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_fire && cmd_bad;
      unique case (state_q)
        IDLE: begin
          if (cmd_fire && !cmd_bad) begin
            k_q   <= cmd_count;
            m_q   <= cmd_count;
            rem_q <= cmd_num;
            idx_q <= '0;
            vec_q <= '0;
          end
        end
        BUILD: begin
          vec_q[idx_q] <= take_bit;
          if (take_bit) begin
            m_q <= m_q - ONE_CW;
          end
          idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + ONE_CW;
        end
        PRESENT: begin
          if (out_fire) begin
            rem_q <= rem_q - ONE_NUM;
            if (rem_q != ONE_NUM) begin
              idx_q <= '0;
              m_q   <= k_q;
              vec_q <= '0;
            end
          end
        end
        default: begin
          idx_q <= '0;
        end
      endcase
    end
  end

  // Outputs decode from state so that reset drops them without waiting for a clock.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == PRESENT);
    out_last  = (state_q == PRESENT) && (rem_q == ONE_NUM);
    out_vec   = vec_q;
    out_count = k_q;
    err       = err_q;
  end

endmodule
